// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART transmitter; define ARB_TAG_EN for a per-grant header byte
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 16,
   parameter int STALL_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_valid,
   output logic [7:0]                 tx_data,
   input  logic                       tx_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);
   localparam int IW = $clog2(NUM_REQ);
`ifdef ARB_TAG_EN
   typedef enum logic [1:0] {IDLE, TAG, PASS} state_t;
`else
   typedef enum logic [1:0] {IDLE, PASS} state_t;
`endif
   state_t state, state_nxt;
   logic [IW-1:0] grant_nxt, cand;
   logic [7:0] burst_cnt, burst_nxt, stall_cnt, stall_nxt, g_data;
   logic found, g_valid, g_last;
   assign g_valid = req_valid[grant_id];
   assign g_last = req_last[grant_id];
   assign g_data = req_data[8*grant_id +: 8];
   assign busy = state != IDLE;
   // round-robin pick: first requesting index after the last grant, wrapping back to itself
   always_comb begin
      found = 1'b0;
      cand = grant_id;
      grant_nxt = grant_id;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(grant_id) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            grant_nxt = cand;
         end
      end
   end
   // next state, burst/stall counting and the combinational pass-through to the transmitter
   always_comb begin
      state_nxt = state;
      burst_nxt = burst_cnt;
      stall_nxt = stall_cnt;
      req_ready = '0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      case (state)
         IDLE: begin
`ifdef ARB_TAG_EN
            if (found) state_nxt = TAG;
`else
            if (found) state_nxt = PASS;
`endif
         end
`ifdef ARB_TAG_EN
         TAG: begin
            tx_valid = 1'b1;
            tx_data = {4'hA, 1'b0, 3'(grant_id)};
            if (tx_ready) state_nxt = PASS;
         end
`endif
         PASS: begin
            tx_valid = g_valid;
            tx_data = g_data;
            req_ready[grant_id] = tx_ready;
            if (g_valid && tx_ready) begin
               burst_nxt = burst_cnt + 8'd1;
               stall_nxt = 8'd0;
               if (g_last || burst_nxt == 8'(MAX_BURST)) state_nxt = IDLE;
            end else if (!g_valid) begin
               stall_nxt = stall_cnt + 8'd1;
               if (stall_nxt == 8'(STALL_CYCLES)) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt == IDLE) begin
         burst_nxt = 8'd0;
         stall_nxt = 8'd0;
      end
   end
   // state, grant and counters; reset parks the pointer on the last index so requester 0 wins first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         grant_id <= IW'(NUM_REQ - 1);
         burst_cnt <= 8'd0;
         stall_cnt <= 8'd0;
      end else begin
         state <= state_nxt;
         grant_id <= (state == IDLE && found) ? grant_nxt : grant_id;
         burst_cnt <= burst_nxt;
         stall_cnt <= stall_nxt;
      end
   end
endmodule
